ce_gen: RTL and testbench

- Parametrised multi-channel clock-enable strobe generator running on the system clock.
- Generalises the fixed CPU/pixel/PIT/DMA/PS2 divider chain into NCH independent channels.
- Each channel has a run-time divisor, a phase offset and a turbo (double-rate) mode.
- Divisor, phase and turbo changes take effect glitch-free, only at that channel's period wrap.
- Strobes feed ce/pin_f1/pin_f2-style inputs of CPU, PIT, DMA, CRT and PS2 logic.

---
 rtl/ce_gen_pkg.sv | 29 ++
 rtl/ce_gen_chan.sv | 112 +++++++++++
 rtl/ce_gen.sv | 54 +++++
 tb/tb_ce_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_gen_pkg.sv
// Shared constants, channel configuration record and turbo second-phase helper
// for the ce_gen clock-enable strobe generator.
package ce_gen_pkg;

    localparam int CE_CNT_W_DEF = 12;
    localparam int CE_CNT_W_MAX = 16;

    typedef struct packed {
        logic [CE_CNT_W_MAX-1:0] div;
        logic [CE_CNT_W_MAX-1:0] phase;
        logic                    turbo;
    } ce_cfg_t;

    // Half a period after phase, wrapped back into [0, div]; one extra bit
    // keeps period = div+1 exact even at the maximum divisor.
    function automatic logic [CE_CNT_W_MAX-1:0] ce_phase2(
        input logic [CE_CNT_W_MAX-1:0] div,
        input logic [CE_CNT_W_MAX-1:0] phase
    );
        logic [CE_CNT_W_MAX:0] period;
        logic [CE_CNT_W_MAX:0] sum;
        logic [CE_CNT_W_MAX:0] res;
        period = {1'b0, div} + (CE_CNT_W_MAX+1)'(1);
        sum    = {1'b0, phase} + (period >> 1);
        res    = (sum >= period) ? (sum - period) : sum;
        return CE_CNT_W_MAX'(res);
    endfunction

endpackage

// File: rtl/ce_gen_chan.sv
// One strobe channel: period counter, shadow/active configuration pipe and
// registered ce / wrap / cfg_err outputs.
module ce_gen_chan
    import ce_gen_pkg::*;
#(
    parameter int               CNT_W     = CE_CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV   = CNT_W'(27),
    parameter logic [CNT_W-1:0] DEF_PHASE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic [CNT_W-1:0] cfg_phase_i,
    input  logic             cfg_turbo_i,
    input  logic             cfg_load_i,
    input  logic             resync_i,
    input  logic             run_i,
    output logic             ce_o,
    output logic             wrap_o,
    output logic             cfg_err_o
);

    localparam ce_cfg_t CFG_RST = '{
        div:   CE_CNT_W_MAX'(DEF_DIV),
        phase: CE_CNT_W_MAX'(DEF_PHASE),
        turbo: 1'b0
    };

    ce_cfg_t                 cfg_in;
    ce_cfg_t                 shd_q;
    ce_cfg_t                 shd_d;
    ce_cfg_t                 act_q;
    ce_cfg_t                 act_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    from_wrap_q;
    logic                    from_wrap_d;
    logic                    ce_q;
    logic                    ce_d;
    logic                    wrap_q;
    logic                    wrap_d;
    logic                    err_q;
    logic                    err_d;
    logic [CE_CNT_W_MAX-1:0] cnt_w;
    logic [CE_CNT_W_MAX-1:0] phase2;
    logic                    at_end;
    logic                    apply;
    logic                    phase_ok;
    logic                    hit;

    always_comb begin
        cfg_in.div   = CE_CNT_W_MAX'(cfg_div_i);
        cfg_in.phase = CE_CNT_W_MAX'(cfg_phase_i);
        cfg_in.turbo = cfg_turbo_i;

        cnt_w  = CE_CNT_W_MAX'(cnt_q);
        at_end = run_i && (cnt_w == act_q.div);
        apply  = resync_i || at_end;

        // A load in the apply cycle bypasses the shadow so the newest value wins.
        shd_d = cfg_load_i ? cfg_in : shd_q;
        act_d = apply ? shd_d : act_q;

        if (apply) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        phase_ok = (act_q.phase <= act_q.div);
        phase2   = ce_phase2(act_q.div, act_q.phase);
        hit      = (cnt_w == act_q.phase) || (act_q.turbo && (cnt_w == phase2));

        ce_d   = run_i && phase_ok && hit;
        wrap_d = run_i && from_wrap_q;
        err_d  = !phase_ok;

        // Marks the cycle spent at 0 after a natural wrap; held while frozen.
        if (run_i) begin
            from_wrap_d = at_end;
        end else begin
            from_wrap_d = from_wrap_q && !resync_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shd_q       <= CFG_RST;
            act_q       <= CFG_RST;
            cnt_q       <= '0;
            from_wrap_q <= 1'b0;
            ce_q        <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shd_q       <= shd_d;
            act_q       <= act_d;
            cnt_q       <= cnt_d;
            from_wrap_q <= from_wrap_d;
            ce_q        <= ce_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    assign ce_o      = ce_q;
    assign wrap_o    = wrap_q;
    assign cfg_err_o = err_q;

endmodule

// File: rtl/ce_gen.sv
// NCH-channel clock-enable strobe generator. Defining CE_GEN_GATE_EN adds the
// per-channel gate input that freezes a channel's counter and strobes.
module ce_gen
    import ce_gen_pkg::*;
#(
    parameter int                   NCH       = 4,
    parameter int                   CNT_W     = CE_CNT_W_DEF,
    parameter logic [NCH*CNT_W-1:0] DEF_DIV   = {NCH{CNT_W'(27)}},
    parameter logic [NCH*CNT_W-1:0] DEF_PHASE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH*CNT_W-1:0] cfg_div,
    input  logic [NCH*CNT_W-1:0] cfg_phase,
    input  logic [NCH-1:0]       cfg_turbo,
    input  logic [NCH-1:0]       cfg_load,
    input  logic                 resync,
`ifdef CE_GEN_GATE_EN
    input  logic [NCH-1:0]       gate,
`endif
    output logic [NCH-1:0]       ce,
    output logic [NCH-1:0]       wrap,
    output logic [NCH-1:0]       cfg_err
);

    logic [NCH-1:0] run;

`ifdef CE_GEN_GATE_EN
    assign run = gate;
`else
    assign run = '1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        ce_gen_chan #(
            .CNT_W     (CNT_W),
            .DEF_DIV   (DEF_DIV[i*CNT_W +: CNT_W]),
            .DEF_PHASE (DEF_PHASE[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .cfg_div_i   (cfg_div[i*CNT_W +: CNT_W]),
            .cfg_phase_i (cfg_phase[i*CNT_W +: CNT_W]),
            .cfg_turbo_i (cfg_turbo[i]),
            .cfg_load_i  (cfg_load[i]),
            .resync_i    (resync),
            .run_i       (run[i]),
            .ce_o        (ce[i]),
            .wrap_o      (wrap[i]),
            .cfg_err_o   (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_ce_gen.sv
// Directed plus randomized bench for ce_gen against a behavioural channel model.
`timescale 1ns/1ps
module tb_ce_gen;

    localparam int NCH   = 4;
    localparam int CNT_W = 12;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NCH*CNT_W-1:0] cfg_div;
    logic [NCH*CNT_W-1:0] cfg_phase;
    logic [NCH-1:0]       cfg_turbo;
    logic [NCH-1:0]       cfg_load;
    logic                 resync;
    logic [NCH-1:0]       gate;
    logic [NCH-1:0]       ce;
    logic [NCH-1:0]       wrap;
    logic [NCH-1:0]       cfg_err;

    ce_gen #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_turbo (cfg_turbo),
        .cfg_load  (cfg_load),
        .resync    (resync),
`ifdef CE_GEN_GATE_EN
        .gate      (gate),
`endif
        .ce        (ce),
        .wrap      (wrap),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // requested config driven onto the bus
    int c_div [NCH];
    int c_ph  [NCH];
    bit c_tb  [NCH];

    // reference model: active + shadow config, counter position
    int m_cnt [NCH];
    int m_div [NCH];
    int m_ph  [NCH];
    bit m_tb  [NCH];
    int s_div [NCH];
    int s_ph  [NCH];
    bit s_tb  [NCH];
    bit m_fw  [NCH];
    bit e_ce  [NCH];
    bit e_wrap[NCH];
    bit e_err [NCH];

    // observed strobe spacing
    int last_ce[NCH];
    int gap    [NCH];
    int pgap   [NCH];
    int nce    [NCH];

    task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ch%0d: observed %0d expected %0d at cycle %0d", tag, ch, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            cfg_div[i*CNT_W +: CNT_W]   = CNT_W'(c_div[i]);
            cfg_phase[i*CNT_W +: CNT_W] = CNT_W'(c_ph[i]);
            cfg_turbo[i]                = c_tb[i];
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            int per;
            int p2;
            bit run;
            bit at_end;
            run       = gate[i];
            per       = m_div[i] + 1;
            p2        = (m_ph[i] + per / 2) % per;
            e_err[i]  = (m_ph[i] > m_div[i]);
            e_ce[i]   = run && !e_err[i] && (m_cnt[i] == m_ph[i] || (m_tb[i] && m_cnt[i] == p2));
            e_wrap[i] = run && m_fw[i];
            if (cfg_load[i]) begin
                s_div[i] = c_div[i];
                s_ph[i]  = c_ph[i];
                s_tb[i]  = c_tb[i];
            end
            at_end = run && (m_cnt[i] == m_div[i]);
            if (resync || at_end) begin
                m_div[i] = s_div[i];
                m_ph[i]  = s_ph[i];
                m_tb[i]  = s_tb[i];
            end
            m_fw[i] = run ? at_end : (m_fw[i] && !resync);
            if (resync || at_end) m_cnt[i] = 0;
            else if (run)         m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic tick();
        drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            chk("ce", i, ce[i], e_ce[i]);
            chk("wrap", i, wrap[i], e_wrap[i]);
            chk("cfg_err", i, cfg_err[i], e_err[i]);
            if (ce[i] === 1'b1) begin
                pgap[i]    = gap[i];
                gap[i]     = cyc - last_ce[i];
                last_ce[i] = cyc;
                nce[i]++;
            end
        end
        cfg_load = '0;
        resync   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_cfg(input int ch, input int dv, input int ph, input bit tb);
        c_div[ch]    = dv;
        c_ph[ch]     = ph;
        c_tb[ch]     = tb;
        cfg_load[ch] = 1'b1;
    endtask

    task automatic wait_cnt(input int ch, input int val, input int budget);
        bit found;
        found = (m_cnt[ch] == val);
        for (int k = 0; k < budget && !found; k++) begin
            tick();
            found = (m_cnt[ch] == val);
        end
        chk("wait_cnt", ch, 32'(found), 1);
    endtask

    initial begin
        reset_n  = 1'b0;
        cfg_load = '0;
        resync   = 1'b0;
        gate     = '1;
        for (int i = 0; i < NCH; i++) begin
            c_div[i] = 27; c_ph[i] = 0; c_tb[i] = 1'b0;
            m_cnt[i] = 0;  m_div[i] = 27; m_ph[i] = 0; m_tb[i] = 1'b0;
            s_div[i] = 27; s_ph[i] = 0;   s_tb[i] = 1'b0;
            m_fw[i]  = 1'b0;
            last_ce[i] = 0; gap[i] = 0; pgap[i] = 0; nce[i] = 0;
        end
        drive();
        repeat (3) @(negedge clk);
        chk("rst_ce", 0, 32'(ce), 0);
        chk("rst_wrap", 0, 32'(wrap), 0);
        chk("rst_cfg_err", 0, 32'(cfg_err), 0);
        reset_n = 1'b1;

        // defaults: first strobe one cycle after release, then every 28
        tick();
        chk("first_ce", 0, ce[0], 1);
        chk("first_wrap", 0, wrap[0], 0);
        ticks(60);
        chk("gap_default", 0, gap[0], 28);

        // turbo loaded mid-period on ch0
        wait_cnt(0, 5, 40);
        set_cfg(0, 27, 0, 1'b1);
        ticks(80);
        chk("turbo_gap", 0, gap[0], 14);
        chk("turbo_pgap", 0, pgap[0], 14);

        // odd and even short periods with turbo
        set_cfg(0, 5, 2, 1'b1);
        set_cfg(1, 4, 0, 1'b1);
        ticks(40);
        chk("div5_gap", 0, gap[0], 3);
        chk("div5_pgap", 0, pgap[0], 3);
        chk("div4_sum", 1, gap[1] + pgap[1], 5);
        chk("div4_min", 1, (gap[1] < pgap[1]) ? gap[1] : pgap[1], 2);

        // phase out of range then repaired
        set_cfg(2, 3, 7, 1'b0);
        ticks(40);
        nce[2] = 0;
        ticks(20);
        chk("err_set", 2, cfg_err[2], 1);
        chk("err_no_ce", 2, nce[2], 0);
        set_cfg(2, 3, 1, 1'b0);
        ticks(20);
        chk("err_clr", 2, cfg_err[2], 0);
        chk("err_clr_gap", 2, gap[2], 4);

        // resync applies pending shadows and realigns
        set_cfg(0, 27, 0, 1'b0);
        set_cfg(1, 5, 0, 1'b0);
        tick();
        resync = 1'b1;
        tick();
        tick();
        chk("resync_ce0", 0, ce[0], 1);
        chk("resync_ce1", 1, ce[1], 1);
        ticks(30);
        chk("resync_gap0", 0, gap[0], 28);
        chk("resync_gap1", 1, gap[1], 6);

        // random configuration traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int dv;
                    dv = $urandom_range(0, 40);
                    set_cfg(i, dv, $urandom_range(0, dv + 3), 1'($urandom_range(0, 1)));
                end
            end
            if ($urandom_range(0, 59) == 0) resync = 1'b1;
            tick();
        end

`ifdef CE_GEN_GATE_EN
        // freeze ch2 at cnt 3 for 10 cycles
        set_cfg(2, 27, 0, 1'b0);
        ticks(60);
        wait_cnt(2, 3, 40);
        nce[2] = 0;
        gate[2] = 1'b0;
        ticks(10);
        gate[2] = 1'b1;
        chk("gate_no_ce", 2, nce[2], 0);
        for (int k = 0; k < 40 && nce[2] == 0; k++) tick();
        chk("gate_gap", 2, gap[2], 38);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
